// File: rtl/wb_pkg.sv
// Shared types for the MEM-to-WB skid stage: load codes, buffer occupancy
// states and the default-width pipeline entry.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_RAW  = 5;
    localparam int WB_LDW  = 3;

    typedef enum logic [WB_LDW-1:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [WB_RAW-1:0]  rd;
        logic [WB_XLEN-1:0] alu_q;
        logic [WB_LDW-1:0]  ld_type;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_stage.sv
// MEM-to-WB pipeline stage with a 2-entry skid buffer and valid/ready handshake.
// Optional WB_SKID_PERF_EN adds saturating stall_cnt / full_cnt outputs.
module wb_skid_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int LDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_alu_q,
    input  logic [LDW-1:0]  in_ld_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RAW-1:0]  out_rd,
    output logic [XLEN-1:0] out_alu_q,
    output logic [LDW-1:0]  out_ld_type,
    output logic            out_load
`ifdef WB_SKID_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     full_cnt
`endif
);

    // Same layout as wb_entry_t, but sized by this instance's parameters so
    // RV32E or wider payload builds keep working.
    typedef struct packed {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] alu_q;
        logic [LDW-1:0]  ld_type;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    skid_state_e state_reg;
    entry_t      main_reg;
    entry_t      skid_reg;
    entry_t      in_entry;
    logic        in_fire;
    logic        out_fire;

    assign in_entry = '{rd: in_rd, alu_q: in_alu_q, ld_type: in_ld_type};

    // Handshake flags are pure decodes of the state register, so in_ready
    // never sees out_ready or in_valid combinationally.
    assign in_ready  = (state_reg != ST_TWO);
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_rd      = main_reg.rd;
    assign out_alu_q   = main_reg.alu_q;
    assign out_ld_type = main_reg.ld_type;
    assign out_load    = out_valid && (main_reg.ld_type != LDW'(LD_NONE));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_reg <= ST_EMPTY;
            main_reg  <= ENTRY_ZERO;
            skid_reg  <= ENTRY_ZERO;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_reg  <= in_entry;
                        state_reg <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_reg <= in_entry;
                    end else if (in_fire) begin
                        skid_reg  <= in_entry;
                        state_reg <= ST_TWO;
                    end else if (out_fire) begin
                        main_reg  <= ENTRY_ZERO;
                        state_reg <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_reg  <= skid_reg;
                        skid_reg  <= ENTRY_ZERO;
                        state_reg <= ST_ONE;
                    end
                end
                default: begin
                    state_reg <= ST_EMPTY;
                    main_reg  <= ENTRY_ZERO;
                    skid_reg  <= ENTRY_ZERO;
                end
            endcase
        end
    end

`ifdef WB_SKID_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] full_cnt_reg;

    // Counters survive flush on purpose: they measure the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            full_cnt_reg  <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if ((state_reg == ST_TWO) && !(&full_cnt_reg))
                full_cnt_reg <= full_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign full_cnt  = full_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Directed self-checking bench for wb_skid_stage; define WB_SKID_PERF_EN to
// also exercise the performance counters.
module tb_wb_skid_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int LDW  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [RAW-1:0]  in_rd = '0;
    logic [XLEN-1:0] in_alu_q = '0;
    logic [LDW-1:0]  in_ld_type = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RAW-1:0]  out_rd;
    logic [XLEN-1:0] out_alu_q;
    logic [LDW-1:0]  out_ld_type;
    logic            out_load;
`ifdef WB_SKID_PERF_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     full_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_skid_stage #(.XLEN(XLEN), .RAW(RAW), .LDW(LDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_alu_q   (in_alu_q),
        .in_ld_type (in_ld_type),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_alu_q  (out_alu_q),
        .out_ld_type(out_ld_type),
        .out_load   (out_load)
`ifdef WB_SKID_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .full_cnt   (full_cnt)
`endif
    );

    // Advance one rising edge and settle; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RAW-1:0] rd,
                         input logic [XLEN-1:0] q, input logic [LDW-1:0] ld);
        in_valid   = v;
        in_rd      = rd;
        in_alu_q   = q;
        in_ld_type = ld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_rd !== '0 || out_alu_q !== '0 ||
            out_ld_type !== '0 || out_load !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b rd=%0d q=%h ld=%0d load=%b, want all 0",
                     out_valid, out_rd, out_alu_q, out_ld_type, out_load);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        drive(1'b1, 5'd5, 32'h1000, 3'd3);
        step();
        drive(1'b0, '0, '0, '0);
        tests++;
        if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_alu_q !== 32'h1000 ||
            out_ld_type !== 3'd3 || out_load !== 1'b1) begin
            fails++;
            $display("FAIL first_entry: got v=%b rd=%0d q=%h ld=%0d load=%b, want 1/5/1000/3/1",
                     out_valid, out_rd, out_alu_q, out_ld_type, out_load);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_rd !== '0 || out_alu_q !== '0 || out_load !== 1'b0) begin
            fails++;
            $display("FAIL drain_zero: got v=%b rd=%0d q=%h load=%b, want 0/0/0/0",
                     out_valid, out_rd, out_alu_q, out_load);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'h11, 3'd0);
        step();
        drive(1'b1, 5'd2, 32'h22, 3'd6);
        step();
        drive(1'b0, '0, '0, '0);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1 ||
            out_alu_q !== 32'h11 || out_load !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: got rdy=%b v=%b rd=%0d q=%h load=%b, want 0/1/1/11/0",
                     in_ready, out_valid, out_rd, out_alu_q, out_load);
        end
        step();
        tests++;
        if (out_rd !== 5'd1 || out_alu_q !== 32'h11) begin
            fails++;
            $display("FAIL bp_hold: got rd=%0d q=%h, want 1/11", out_rd, out_alu_q);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd2 ||
            out_alu_q !== 32'h22 || out_ld_type !== 3'd6 || out_load !== 1'b1) begin
            fails++;
            $display("FAIL bp_pop_a: got rdy=%b v=%b rd=%0d q=%h ld=%0d load=%b, want 1/1/2/22/6/1",
                     in_ready, out_valid, out_rd, out_alu_q, out_ld_type, out_load);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_alu_q !== '0 || out_ld_type !== '0) begin
            fails++;
            $display("FAIL bp_pop_b: got v=%b q=%h ld=%0d, want 0/0/0",
                     out_valid, out_alu_q, out_ld_type);
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, RAW'(i + 1), XLEN'(i), LDW'(i % 6));
            step();
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_alu_q !== XLEN'(i) ||
                out_rd !== RAW'(i + 1)) begin
                fails++;
                $display("FAIL stream_%0d: got v=%b rdy=%b rd=%0d q=%h, want 1/1/%0d/%h",
                         i, out_valid, in_ready, out_rd, out_alu_q, i + 1, i);
            end
        end
        drive(1'b0, '0, '0, '0);
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end: got v=%b want 0", out_valid);
        end
        $display("[TB] test_streaming done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 32'h33, 3'd1);
        step();
        drive(1'b1, 5'd4, 32'h44, 3'd0);
        out_ready = 1'b1;
        step();
        drive(1'b0, '0, '0, '0);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_rd !== 5'd4 ||
            out_alu_q !== 32'h44 || out_load !== 1'b0) begin
            fails++;
            $display("FAIL simul_fire: got v=%b rdy=%b rd=%0d q=%h load=%b, want 1/1/4/44/0",
                     out_valid, in_ready, out_rd, out_alu_q, out_load);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL simul_drain: got v=%b want 0", out_valid);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 5'd7, 32'h77, 3'd2);
        step();
        drive(1'b1, 5'd8, 32'h88, 3'd3);
        step();
        drive(1'b1, 5'd9, 32'h99, 3'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rd !== '0 ||
            out_alu_q !== '0 || out_ld_type !== '0) begin
            fails++;
            $display("FAIL flush_two: got v=%b rdy=%b rd=%0d q=%h ld=%0d, want 0/1/0/0/0",
                     out_valid, in_ready, out_rd, out_alu_q, out_ld_type);
        end
        // Flush in ONE with in_ready high: the accepted input must be dropped.
        drive(1'b1, 5'd10, 32'hAA, 3'd1);
        step();
        drive(1'b1, 5'd11, 32'hBB, 3'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || out_alu_q !== '0) begin
            fails++;
            $display("FAIL flush_one_drop: got v=%b q=%h, want 0/0", out_valid, out_alu_q);
        end
        out_ready = 1'b0;
        $display("[TB] test_flush done");
    endtask

`ifdef WB_SKID_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        tests++;
        if (stall_cnt !== 32'd0 || full_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset: got stall=%0d full=%0d, want 0/0", stall_cnt, full_cnt);
        end
        drive(1'b1, 5'd1, 32'h1, 3'd0);
        step();
        drive(1'b1, 5'd2, 32'h2, 3'd0);
        step();
        drive(1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) step();
        // One stalled cycle in ONE before filling, then ten in TWO.
        tests++;
        if (stall_cnt !== 32'd11 || full_cnt !== 32'd10) begin
            fails++;
            $display("FAIL perf_count: got stall=%0d full=%0d, want 11/10", stall_cnt, full_cnt);
        end
        out_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (stall_cnt !== 32'd11 || full_cnt !== 32'd11 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL perf_flush: got stall=%0d full=%0d v=%b, want 11/11/0",
                     stall_cnt, full_cnt, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (stall_cnt !== 32'd0 || full_cnt !== 32'd0) begin
            fails++;
            $display("FAIL perf_clear: got stall=%0d full=%0d, want 0/0", stall_cnt, full_cnt);
        end
        $display("[TB] test_perf done");
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_backpressure();
        test_streaming();
        test_back_to_back();
        test_flush();
`ifdef WB_SKID_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
